// File: rtl/bmc_rx_dec.sv
// USB PD BMC receive decoder: recovers bits from the AFE comparator with adaptive UI tracking.
// Optional macro BMC_RX_DEGLITCH_EN inserts a 3-sample majority filter after the data synchronizer.
module bmc_rx_dec #(
    parameter int CNT_W      = 8,
    parameter int UI_INIT    = 40,
    parameter int GLITCH_MIN = 4,
    parameter int PRE_BITS   = 16
) (
    input  logic i_clk,
    input  logic i_rstz,
    input  logic i_en,
    input  logic i_rx_dat,
    input  logic i_rx_sql,
    output logic o_bit,
    output logic o_bit_vld,
    output logic o_lock,
    output logic o_eop,
    output logic o_err,
    output logic o_busy
);
    localparam int AW = $clog2(PRE_BITS + 1);

    typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_t;

    state_t           st, st_n;
    logic [1:0]       dat_sync, sql_sync;
    logic             dat_f, dat_q, edge_r;
    logic [CNT_W-1:0] cnt, ival, thr, to_lim;
    logic [CNT_W-1:0] ui_len, ui_n, half_len, half_n;
    logic [CNT_W:0]   to_wide, sum_wide;
    logic [AW-1:0]    alt_cnt, alt_n;
    logic             pend, pend_n, prev_bit, prev_n;
    logic             lock_n, bit_n, vld_n, eop_n, err_n;
    logic             half, glitch, timeout, go_idle;

`ifdef BMC_RX_DEGLITCH_EN
    logic [1:0] dat_hist;

    always_ff @(posedge i_clk) begin
        if (!i_rstz) dat_hist <= '0;
        else         dat_hist <= {dat_hist[0], dat_sync[1]};
    end

    assign dat_f = (dat_sync[1] & dat_hist[0]) | (dat_sync[1] & dat_hist[1]) |
                   (dat_hist[0] & dat_hist[1]);
`else
    assign dat_f = dat_sync[1];
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rstz) begin
            dat_sync <= '0;
            sql_sync <= '0;
            dat_q    <= 1'b0;
            edge_r   <= 1'b0;
            cnt      <= '0;
        end else begin
            dat_sync <= {dat_sync[0], i_rx_dat};
            sql_sync <= {sql_sync[0], i_rx_sql};
            dat_q    <= dat_f;
            edge_r   <= dat_f ^ dat_q;
            cnt      <= edge_r ? '0 : ival;
        end
    end

    // ival is the full edge-to-edge interval in clocks, including the current cycle
    assign ival     = (&cnt) ? cnt : cnt + 1'b1;
    assign thr      = (ui_len >> 1) + (ui_len >> 2);
    assign to_wide  = {1'b0, ui_len} + {2'b0, ui_len[CNT_W-1:1]};
    assign to_lim   = to_wide[CNT_W] ? {CNT_W{1'b1}} : to_wide[CNT_W-1:0];
    assign sum_wide = {1'b0, half_len} + {1'b0, ival};
    assign half     = ival < thr;
    assign glitch   = ival < CNT_W'(GLITCH_MIN);
    assign timeout  = !edge_r && (ival >= to_lim);

    always_comb begin
        st_n    = st;
        ui_n    = ui_len;
        half_n  = half_len;
        pend_n  = pend;
        prev_n  = prev_bit;
        alt_n   = alt_cnt;
        lock_n  = o_lock;
        bit_n   = 1'b0;
        vld_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        go_idle = 1'b0;
        if (st == IDLE) begin
            if (edge_r && sql_sync[1] && i_en) st_n = TRAIN;
        end else if (!sql_sync[1] || !i_en) begin
            go_idle = 1'b1;
        end else if (edge_r) begin
            if (glitch || (pend && !half)) begin
                err_n   = 1'b1;
                go_idle = 1'b1;
            end else if (pend || !half) begin
                // a pending half completes a 1; a lone full interval is a 0
                pend_n = 1'b0;
                ui_n   = pend ? (sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0]) : ival;
                if (st == DATA) begin
                    vld_n = 1'b1;
                    bit_n = pend;
                end else begin
                    alt_n  = (alt_cnt != '0 && pend != prev_bit) ? alt_cnt + 1'b1 : AW'(1);
                    prev_n = pend;
                    if (alt_n == AW'(PRE_BITS)) begin
                        lock_n = 1'b1;
                        st_n   = DATA;
                    end
                end
            end else begin
                pend_n = 1'b1;
                half_n = ival;
            end
        end else if (timeout) begin
            eop_n   = (st == DATA);
            go_idle = 1'b1;
        end
        if (go_idle) begin
            st_n   = IDLE;
            ui_n   = CNT_W'(UI_INIT);
            pend_n = 1'b0;
            alt_n  = '0;
            lock_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstz) begin
            st        <= IDLE;
            ui_len    <= CNT_W'(UI_INIT);
            half_len  <= '0;
            pend      <= 1'b0;
            prev_bit  <= 1'b0;
            alt_cnt   <= '0;
            o_lock    <= 1'b0;
            o_bit     <= 1'b0;
            o_bit_vld <= 1'b0;
            o_eop     <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            st        <= st_n;
            ui_len    <= ui_n;
            half_len  <= half_n;
            pend      <= pend_n;
            prev_bit  <= prev_n;
            alt_cnt   <= alt_n;
            o_lock    <= lock_n;
            o_bit     <= bit_n;
            o_bit_vld <= vld_n;
            o_eop     <= eop_n;
            o_err     <= err_n;
        end
    end

    assign o_busy = (st != IDLE);

endmodule
